// File: rtl/sqrt_sched_pkg.sv
// Shared types, default widths and helpers for the sqrt_scheduler slice.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_INT_WIDTH      = 8;
  localparam int DEF_FRAC_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic int sqrt_sched_id_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search begins at i_ptr.
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = sqrt_sched_id_w(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDW'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_scheduler.sv
// Round-robin scheduler sharing one iterative sqrt engine between NUM_REQ clients.
// Optional watchdog on engine runs: define SQRT_SCHED_TIMEOUT_EN.
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int INT_WIDTH      = DEF_INT_WIDTH,
  parameter int FRAC_WIDTH     = DEF_FRAC_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int W             = INT_WIDTH + FRAC_WIDTH,
  localparam int IDW           = sqrt_sched_id_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 eng_start,
  output logic [W-1:0]         eng_x,
  input  logic                 eng_busy,
  input  logic                 eng_valid,
  input  logic [W-1:0]         eng_sqrt
);

  state_t               r_state;
  logic [IDW-1:0]       r_ptr;
  logic [IDW-1:0]       r_id;
  logic [W-1:0]         r_x;
  logic [W-1:0]         r_data;
  logic                 r_err;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDW-1:0]       w_gid;
  logic [W-1:0]         w_gdata;
  logic                 w_accept;
  logic                 w_wdog_exp;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_gid   = '0;
    w_gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gid   = IDW'(i);
        w_gdata = req_data[i*W +: W];
      end
    end
  end

  assign w_accept  = (r_state == IDLE) && (|w_grant);
  assign req_ready = (rst_n && r_state == IDLE) ? w_grant : '0;
  // Start stays up until busy is seen: the engine drops start in its post-result cycle.
  assign eng_start = rst_n && (r_state == LAUNCH) && !eng_busy;
  assign eng_x     = r_x;
  assign rsp_valid = rst_n && (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

`ifdef SQRT_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_wdog <= '0;
    else if (w_accept)
      r_wdog <= '0;
    else if (r_state == LAUNCH || r_state == WAIT)
      r_wdog <= r_wdog + 1'b1;
  end

  assign w_wdog_exp = (r_state == LAUNCH || r_state == WAIT) &&
                      (r_wdog == WDW'(TIMEOUT_CYCLES - 1));
`else
  assign w_wdog_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_x     <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_id <= w_gid;
          r_x  <= w_gdata;
          if (w_gdata[W-1]) begin
            r_data  <= '0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_state <= LAUNCH;
          end
        end
        LAUNCH: if (w_wdog_exp) begin
          r_data  <= '0;
          r_err   <= 1'b1;
          r_state <= RESP;
        end else if (eng_busy) begin
          r_state <= WAIT;
        end
        WAIT: if (eng_valid) begin
          r_data  <= eng_sqrt;
          r_err   <= 1'b0;
          r_state <= RESP;
        end else if (w_wdog_exp) begin
          r_data  <= '0;
          r_err   <= 1'b1;
          r_state <= RESP;
        end
        RESP: if (rsp_ready) begin
          r_ptr   <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler with a 16-iteration behavioural engine model.
module tb_sqrt_scheduler;

  localparam int NR = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [63:0]   req_data;
  logic [NR-1:0] req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic          eng_start;
  logic [15:0]   eng_x;
  logic          eng_busy;
  logic          eng_valid;
  logic [15:0]   eng_sqrt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_start = 0;

  logic        m_busy = 1'b0;
  logic        m_ign  = 1'b0;
  logic        m_nostrobe = 1'b0;
  int          m_cnt  = 0;
  logic [15:0] m_x    = '0;

  sqrt_scheduler #(
    .NUM_REQ(NR), .INT_WIDTH(8), .FRAC_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_x(eng_x), .eng_busy(eng_busy),
    .eng_valid(eng_valid), .eng_sqrt(eng_sqrt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (eng_start) n_start <= n_start + 1;

  function automatic logic [15:0] isqrt24(input logic [23:0] v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return r[15:0];
  endfunction

  // Engine model: busy the cycle after start, strobe 16 cycles later, then one start-ignore cycle.
  always @(posedge clk) begin
    m_ign <= 1'b0;
    if (m_busy) begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else if (!m_nostrobe) begin
        m_busy <= 1'b0;
        m_ign  <= 1'b1;
      end
    end else if (eng_start && !m_ign) begin
      m_busy <= 1'b1;
      m_cnt  <= 16;
      m_x    <= eng_x;
    end
  end

  assign eng_busy  = m_busy;
  assign eng_valid = m_busy && (m_cnt == 0) && !m_nostrobe;
  assign eng_sqrt  = isqrt24({m_x, 8'h00});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input int t0, input int maxc, output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < maxc);
    lat = cyc - t0;
    if (!rsp_valid) chk("rsp_wait", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic send(input int idx, input logic [15:0] d, output int t0);
    @(posedge clk); #1;
    req_valid[idx] = 1'b1;
    req_data[idx*16 +: 16] = d;
    t0 = cyc;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        t0 = cyc;
        break;
      end
    end
    chk("grant", {60'd0, req_ready}, 64'd1 << idx);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  logic [15:0] exp2 [4];
  int t0, lat;
  int s0;
  logic seen;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    exp2[0] = 16'h0100; exp2[1] = 16'h0300; exp2[2] = 16'h0400; exp2[3] = 16'h0080;
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs", {23'd0, req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_x}, 64'd0);

    // All four at once from pointer 0: service order 0,1,2,3.
    @(posedge clk); #1;
    req_data = {16'h0040, 16'h1000, 16'h0900, 16'h0100};
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      t0 = cyc;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (req_ready != 0) begin
          t0 = cyc;
          break;
        end
      end
      chk("rr_grant", {60'd0, req_ready}, 64'd1 << k);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      wait_rsp(t0, 40, lat);
      chk("rr_lat", 64'(lat), 64'd19);
      chk("rr_rsp", {45'd0, rsp_id, rsp_data, rsp_err}, {45'd0, 2'(k), exp2[k], 1'b0});
    end

    // Pointer back at 0: req0 wins over req3; back-pressure on the response.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_data = {16'h0900, 32'd0, 16'h0400};
    req_valid = 4'b1001;
    @(negedge clk);
    t0 = cyc;
    chk("ptr_wrap_grant", {60'd0, req_ready}, 64'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(t0, 40, lat);
    chk("bp_lat", 64'(lat), 64'd19);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {39'd0, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, eng_start},
          {39'd0, 1'b1, 2'd0, 16'h0200, 1'b0, 4'b0000, 1'b0});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_not_early", {60'd0, req_ready}, 64'd0);
    @(negedge clk);
    t0 = cyc;
    chk("bp_next_grant", {60'd0, req_ready}, 64'h8);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_rsp(t0, 40, lat);
    chk("bp_next_rsp", {45'd0, rsp_id, rsp_data, rsp_err}, {45'd0, 2'd3, 16'h0300, 1'b0});

    // Single requester 2, rsp_ready tied high.
    send(2, 16'h0400, t0);
    wait_rsp(t0, 40, lat);
    chk("r2_lat", 64'(lat), 64'd19);
    chk("r2_rsp", {45'd0, rsp_id, rsp_data, rsp_err}, {45'd0, 2'd2, 16'h0200, 1'b0});

    // Negative operand bypasses the engine.
    s0 = n_start;
    send(1, 16'h8100, t0);
    wait_rsp(t0, 10, lat);
    chk("neg_lat", 64'(lat), 64'd1);
    chk("neg_rsp", {45'd0, rsp_id, rsp_data, rsp_err}, {45'd0, 2'd1, 16'h0000, 1'b1});
    repeat (3) @(negedge clk);
    chk("neg_no_start", 64'(n_start - s0), 64'd0);

    // Reset while waiting on the engine; the late strobe must be dropped.
    send(0, 16'h0100, t0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (eng_valid) seen = 1'b1;
      chk("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    chk("rst_late_strobe", {63'd0, seen}, 64'd1);
    chk("rst_outs", {23'd0, req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_x}, 64'd0);
    send(2, 16'h1000, t0);
    wait_rsp(t0, 40, lat);
    chk("rst_next_lat", 64'(lat), 64'd19);
    chk("rst_next_rsp", {45'd0, rsp_id, rsp_data, rsp_err}, {45'd0, 2'd2, 16'h0400, 1'b0});

`ifdef SQRT_SCHED_TIMEOUT_EN
    m_nostrobe = 1'b1;
    send(1, 16'h0100, t0);
    wait_rsp(t0, TO + 20, lat);
    chk("wdog_lat", 64'(lat), 64'(TO + 1));
    chk("wdog_rsp", {45'd0, rsp_id, rsp_data, rsp_err}, {45'd0, 2'd1, 16'h0000, 1'b1});
    @(posedge clk); #1;
    m_nostrobe = 1'b0;
    repeat (4) @(posedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_scheduler.md
# sqrt_scheduler

Shares one iterative fixed-point square-root engine between NUM_REQ requesters. Arbitrates round-robin, forwards the winning operand to the engine, and returns the tagged result on a single valid/ready response channel. Negative operands are rejected without using the engine. It sits between client datapaths and the engine instance, and owns all engine start sequencing.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- INT_WIDTH, 8, integer bits of the Q operand
- FRAC_WIDTH, 8, fractional bits of the Q operand (W = INT_WIDTH+FRAC_WIDTH)
- TIMEOUT_CYCLES, 64, watchdog limit in cycles, counted from LAUNCH entry
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*W  packed signed operands; requester i uses bits [i*W +: W]
- req_ready  out  NUM_REQ  one-hot accept
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_id  out  $clog2(NUM_REQ)  requester index of the result
- rsp_data  out  W  square root in the same Q format
- rsp_err  out  1  operand negative, or watchdog expired
- eng_start  out  1  engine start
- eng_x  out  W  engine operand (registered)
- eng_busy  in  1  engine busy
- eng_valid  in  1  engine single-cycle result strobe
- eng_sqrt  in  W  engine result

## Operation
- The FSM has four states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - req_ready[i] = grant[i]. grant is the combinational round-robin one-hot over req_valid, searched starting at the pointer.
  - On handshake, capture the operand and id.
  - If the operand MSB is 1: rsp_data=0, rsp_err=1, go to RESP.
  - Otherwise go to LAUNCH.
- **LAUNCH**
  - eng_start = !eng_busy. eng_x holds the captured operand.
  - Go to WAIT on the first cycle eng_busy=1.
  - eng_start is held across the engine's post-result cycle, because the engine ignores start there.
- **WAIT**
  - eng_start=0.
  - On eng_valid: capture eng_sqrt into rsp_data, rsp_err=0, go to RESP.
- **RESP**
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are stable.
  - On rsp_ready: go to IDLE, and set the pointer to (id+1) mod NUM_REQ.
- The pointer advances only on completion, never on grant-only cycles.
- eng_valid is ignored in IDLE, LAUNCH and RESP. Stale strobes from an engine run interrupted by reset are discarded.
- Exactly one operation is in flight. No queueing.
- A requester keeps req_valid/req_data stable until req_ready. Dropping req_valid before grant is legal.
- Zero is a legal operand and goes through the engine.

## Timing
- **Reset values:** state=IDLE, pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, eng_start=0, eng_x=0. The watchdog counter resets to 0.
- **Reset mid-operation:** abandon the job with no response; the engine is not reset.
- **Positive-operand latency:**
  - Acceptance cycle T.
  - eng_start in T+1.
  - eng_busy seen in T+2.
  - For an engine of N iterations, eng_valid arrives in T+2+N and rsp_valid in T+3+N (T+19 for N=16).
- **Negative-operand latency:** rsp_valid in T+1.
- **Throughput:** next acceptance no earlier than the cycle after the rsp handshake.
- **Back-pressure:** rsp_valid is held indefinitely. The engine is idle meanwhile.
- **Simultaneous requests:** one grant per IDLE cycle. Ties are resolved by the pointer.

## Configuration
- Macro: SQRT_SCHED_TIMEOUT_EN.
- **Defined:** a counter runs in LAUNCH and WAIT. When it reaches TIMEOUT_CYCLES without eng_valid, the FSM goes to RESP with rsp_data=0, rsp_err=1. The counter clears on every LAUNCH entry.
- **Undefined:** no counter. LAUNCH and WAIT wait forever. rsp_err reports negative operands only.

## Structure
- Package sqrt_sched_pkg:
  - state_t enum {IDLE, LAUNCH, WAIT, RESP}
  - default width localparams
  - function sqrt_sched_id_w(n) = $clog2(n)
- Sub-module rr_arbiter (NUM_REQ): inputs req and pointer, output one-hot grant, combinational.
- The top holds the FSM, operand/id/result registers, pointer and watchdog.

## Test plan
The bench uses a behavioural engine model: N=16, busy one cycle after start, and a valid pulse followed by one ignore-start cycle.
- Requester 2 sends 0x0400; rsp_ready tied 1 → rsp_valid 19 cycles after acceptance, rsp_id=2, rsp_data=0x0200 (from the model), rsp_err=0.
- All 4 requesters valid at once, pointer 0 → service order 0,1,2,3; each req_ready one-hot; pointer ends at 0.
- Requester 1 sends 0x8100 → rsp_valid next cycle, rsp_err=1, rsp_data=0, eng_start never asserted.
- rsp_ready held low 10 cycles → rsp_* stable throughout, req_ready=0, then the next request is accepted after the handshake.
- With SQRT_SCHED_TIMEOUT_EN defined and the model never strobing → rsp_err=1 exactly TIMEOUT_CYCLES cycles after LAUNCH entry.
- Assert rst_n=0 during WAIT; after release the model emits a late eng_valid → no rsp_valid, all outputs at reset values, next request served normally.
